// File: rtl/sa_rr_allocator_if.sv
// Request/grant bundle between the VC allocation stage, the switch
// allocator and the buffer-read / crossbar logic of the 5-port router.
// The allocator sits on the slave side; the upstream stage drives requests.
interface sa_rr_allocator_if #(
    parameter int NUM_PORTS = 5,
    parameter int NUM_VCS   = 4,
    parameter int PORT_BITS = $clog2(NUM_PORTS),
    parameter int VC_BITS   = $clog2(NUM_VCS)
);
    logic [NUM_PORTS*NUM_VCS-1:0]                req_valid;
    logic [NUM_PORTS*NUM_VCS-1:0][NUM_PORTS-1:0] req_dst_port;
    logic [NUM_PORTS*NUM_VCS-1:0]                req_tail;
    logic [NUM_PORTS*NUM_VCS-1:0]                req_credit_ok;

    logic [NUM_PORTS-1:0]                        in_grant_valid;
    logic [NUM_PORTS-1:0][VC_BITS-1:0]           in_grant_vc;
    logic [NUM_PORTS-1:0]                        out_grant_valid;
    logic [NUM_PORTS-1:0][PORT_BITS-1:0]         out_grant_port;
    logic [NUM_PORTS-1:0]                        out_locked;

    modport master (
        output req_valid, req_dst_port, req_tail, req_credit_ok,
        input  in_grant_valid, in_grant_vc, out_grant_valid, out_grant_port, out_locked
    );

    modport slave (
        input  req_valid, req_dst_port, req_tail, req_credit_ok,
        output in_grant_valid, in_grant_vc, out_grant_valid, out_grant_port, out_locked
    );
endinterface

// File: rtl/sa_rr_allocator.sv
// Separable input-first round-robin switch allocator with wormhole output
// locking. Stage 1 picks one eligible VC per input, stage 2 picks one input
// per output. Grants are combinational; pointers and locks are registered.
// Optional macro SA_GRANT_CNT_EN adds saturating per-output grant counters.
module sa_rr_allocator #(
    parameter int NUM_PORTS = 5,
    parameter int NUM_VCS   = 4,
    parameter int PORT_BITS = $clog2(NUM_PORTS),
    parameter int VC_BITS   = $clog2(NUM_VCS)
) (
    input  logic             clk,
    input  logic             reset,
    sa_rr_allocator_if.slave bus
`ifdef SA_GRANT_CNT_EN
    ,
    output logic [NUM_PORTS-1:0][15:0] grant_count
`endif
);

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lockState_e;

    lockState_e           lockState_q [NUM_PORTS];
    lockState_e           lockState_d [NUM_PORTS];
    logic [PORT_BITS-1:0] ownerPort_q [NUM_PORTS];
    logic [PORT_BITS-1:0] ownerPort_d [NUM_PORTS];
    logic [VC_BITS-1:0]   ownerVc_q   [NUM_PORTS];
    logic [VC_BITS-1:0]   ownerVc_d   [NUM_PORTS];
    logic [VC_BITS-1:0]   inPtr_q     [NUM_PORTS];
    logic [VC_BITS-1:0]   inPtr_d     [NUM_PORTS];
    logic [PORT_BITS-1:0] outPtr_q    [NUM_PORTS];
    logic [PORT_BITS-1:0] outPtr_d    [NUM_PORTS];

    logic [NUM_PORTS*NUM_VCS-1:0] eligible;
    logic [PORT_BITS-1:0]         reqOut  [NUM_PORTS*NUM_VCS];
    logic [NUM_PORTS-1:0]         candValid;
    logic [VC_BITS-1:0]           candVc  [NUM_PORTS];
    logic [PORT_BITS-1:0]         candOut [NUM_PORTS];
    logic [NUM_PORTS-1:0]         outGrant;
    logic [PORT_BITS-1:0]         outPort [NUM_PORTS];
    logic [NUM_PORTS-1:0]         inGrant;

    // Decode each VC's target output and decide whether it may compete this cycle
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                reqOut[p*NUM_VCS+v]   = '0;
                eligible[p*NUM_VCS+v] = 1'b0;
                for (int o = 0; o < NUM_PORTS; o++) begin
                    if (bus.req_dst_port[p*NUM_VCS+v][o]) begin
                        reqOut[p*NUM_VCS+v] = PORT_BITS'(o);
                    end
                end
                if (bus.req_valid[p*NUM_VCS+v] && bus.req_credit_ok[p*NUM_VCS+v] &&
                    $onehot(bus.req_dst_port[p*NUM_VCS+v])) begin
                    if (lockState_q[reqOut[p*NUM_VCS+v]] == UNLOCKED ||
                        (ownerPort_q[reqOut[p*NUM_VCS+v]] == PORT_BITS'(p) &&
                         ownerVc_q[reqOut[p*NUM_VCS+v]] == VC_BITS'(v))) begin
                        eligible[p*NUM_VCS+v] = 1'b1;
                    end
                end
            end
        end
    end

    // Stage 1: per input, round-robin over eligible VCs starting at the input pointer
    always_comb begin
        logic found;
        for (int p = 0; p < NUM_PORTS; p++) begin
            found      = 1'b0;
            candVc[p]  = '0;
            candOut[p] = '0;
            for (int k = 0; k < NUM_VCS; k++) begin
                if (!found && eligible[p*NUM_VCS + (int'(inPtr_q[p]) + k) % NUM_VCS]) begin
                    found      = 1'b1;
                    candVc[p]  = VC_BITS'((int'(inPtr_q[p]) + k) % NUM_VCS);
                    candOut[p] = reqOut[p*NUM_VCS + (int'(inPtr_q[p]) + k) % NUM_VCS];
                end
            end
            candValid[p] = found;
        end
    end

    // Stage 2: per output, round-robin over inputs whose candidate targets it
    always_comb begin
        logic found;
        for (int o = 0; o < NUM_PORTS; o++) begin
            found      = 1'b0;
            outPort[o] = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (!found && candValid[(int'(outPtr_q[o]) + k) % NUM_PORTS] &&
                    int'(candOut[(int'(outPtr_q[o]) + k) % NUM_PORTS]) == o &&
                    (lockState_q[o] == UNLOCKED ||
                     int'(ownerPort_q[o]) == (int'(outPtr_q[o]) + k) % NUM_PORTS)) begin
                    found      = 1'b1;
                    outPort[o] = PORT_BITS'((int'(outPtr_q[o]) + k) % NUM_PORTS);
                end
            end
            outGrant[o] = found;
        end
    end

    // An input is granted when the output its candidate targets picked it
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            inGrant[p] = candValid[p] && outGrant[candOut[p]] &&
                         (outPort[candOut[p]] == PORT_BITS'(p));
        end
    end

    // Drive the grant bus, forcing everything to zero while reset is held
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.in_grant_valid[p]  = reset && inGrant[p];
            bus.in_grant_vc[p]     = (reset && inGrant[p]) ? candVc[p] : '0;
            bus.out_grant_valid[p] = reset && outGrant[p];
            bus.out_grant_port[p]  = (reset && outGrant[p]) ? outPort[p] : '0;
            bus.out_locked[p]      = reset && (lockState_q[p] == LOCKED);
        end
    end

    // Lock FSM and iSLIP pointer update; a locked owner keeps its priority
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            lockState_d[i] = lockState_q[i];
            ownerPort_d[i] = ownerPort_q[i];
            ownerVc_d[i]   = ownerVc_q[i];
            outPtr_d[i]    = outPtr_q[i];
            inPtr_d[i]     = inPtr_q[i];
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (outGrant[o]) begin
                case (lockState_q[o])
                    UNLOCKED: begin
                        outPtr_d[o] = PORT_BITS'((int'(outPort[o]) + 1) % NUM_PORTS);
                        inPtr_d[outPort[o]] = VC_BITS'((int'(candVc[outPort[o]]) + 1) % NUM_VCS);
                        if (!bus.req_tail[int'(outPort[o])*NUM_VCS + int'(candVc[outPort[o]])]) begin
                            lockState_d[o] = LOCKED;
                            ownerPort_d[o] = outPort[o];
                            ownerVc_d[o]   = candVc[outPort[o]];
                        end
                    end
                    LOCKED: begin
                        if (bus.req_tail[int'(outPort[o])*NUM_VCS + int'(candVc[outPort[o]])]) begin
                            lockState_d[o] = UNLOCKED;
                        end
                    end
                    default: lockState_d[o] = UNLOCKED;
                endcase
            end
        end
    end

    // State registers, cleared asynchronously so a reset mid-packet drops all locks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                lockState_q[i] <= UNLOCKED;
                ownerPort_q[i] <= '0;
                ownerVc_q[i]   <= '0;
                outPtr_q[i]    <= '0;
                inPtr_q[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                lockState_q[i] <= lockState_d[i];
                ownerPort_q[i] <= ownerPort_d[i];
                ownerVc_q[i]   <= ownerVc_d[i];
                outPtr_q[i]    <= outPtr_d[i];
                inPtr_q[i]     <= inPtr_d[i];
            end
        end
    end

`ifdef SA_GRANT_CNT_EN
    // Per-output saturating count of cycles in which the output was granted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_count <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (outGrant[o] && grant_count[o] != 16'hFFFF) begin
                    grant_count[o] <= grant_count[o] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sa_rr_allocator.sv
// Bench for sa_rr_allocator: a queue-free rotating-distance model of the
// allocator is compared against the DUT every cycle, and directed scenarios
// pin the model with hand-computed literal expectations.
module tb_sa_rr_allocator;

    localparam int NP = 5;
    localparam int NV = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    sa_rr_allocator_if #(.NUM_PORTS(NP), .NUM_VCS(NV)) bus ();

`ifdef SA_GRANT_CNT_EN
    logic [NP-1:0][15:0] grantCount;
    int                  mCount [NP];
`endif

    sa_rr_allocator #(.NUM_PORTS(NP), .NUM_VCS(NV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef SA_GRANT_CNT_EN
        ,
        .grant_count (grantCount)
`endif
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Model state: round-robin pointers and lock owner (-1 means unlocked)
    int mInPtr  [NP];
    int mOutPtr [NP];
    int mLockP  [NP];
    int mLockV  [NP];

    // Compare one value against its required value and count the outcome
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected grants: each input takes the eligible VC closest after its pointer,
    // each output takes the requesting input closest after its pointer
    function automatic void computeModel(output logic [NP-1:0] eInV, output logic [NP-1:0][1:0] eInVc,
                                         output logic [NP-1:0] eOutV, output logic [NP-1:0][2:0] eOutP);
        int candV [NP];
        int candO [NP];
        eInV = '0; eInVc = '0; eOutV = '0; eOutP = '0;
        for (int p = 0; p < NP; p++) begin
            int best;
            best = NV;
            candV[p] = -1;
            candO[p] = -1;
            for (int v = 0; v < NV; v++) begin
                logic [NP-1:0] dst;
                int o;
                dst = bus.req_dst_port[p*NV+v];
                o = -1;
                for (int b = 0; b < NP; b++) if (dst[b]) o = b;
                if (bus.req_valid[p*NV+v] && bus.req_credit_ok[p*NV+v] && $countones(dst) == 1) begin
                    if (mLockP[o] < 0 || (mLockP[o] == p && mLockV[o] == v)) begin
                        if ((v - mInPtr[p] + NV) % NV < best) begin
                            best = (v - mInPtr[p] + NV) % NV;
                            candV[p] = v;
                            candO[p] = o;
                        end
                    end
                end
            end
        end
        for (int o = 0; o < NP; o++) begin
            int best;
            int win;
            best = NP;
            win = -1;
            for (int p = 0; p < NP; p++) begin
                if (candV[p] >= 0 && candO[p] == o && (mLockP[o] < 0 || mLockP[o] == p)) begin
                    if ((p - mOutPtr[o] + NP) % NP < best) begin
                        best = (p - mOutPtr[o] + NP) % NP;
                        win = p;
                    end
                end
            end
            if (win >= 0) begin
                eOutV[o]    = 1'b1;
                eOutP[o]    = 3'(win);
                eInV[win]   = 1'b1;
                eInVc[win]  = 2'(candV[win]);
            end
        end
    endfunction

    // Advance the model on every clock edge, clearing it whenever reset is asserted
    always @(posedge clk or negedge reset) begin
        logic [NP-1:0]      eInV;
        logic [NP-1:0][1:0] eInVc;
        logic [NP-1:0]      eOutV;
        logic [NP-1:0][2:0] eOutP;
        if (!reset) begin
            for (int i = 0; i < NP; i++) begin
                mInPtr[i] = 0; mOutPtr[i] = 0; mLockP[i] = -1; mLockV[i] = 0;
`ifdef SA_GRANT_CNT_EN
                mCount[i] = 0;
`endif
            end
        end else begin
            computeModel(eInV, eInVc, eOutV, eOutP);
            for (int o = 0; o < NP; o++) begin
                if (eOutV[o]) begin
                    int p;
                    int v;
                    p = int'(eOutP[o]);
                    v = int'(eInVc[p]);
                    if (mLockP[o] < 0) begin
                        mOutPtr[o] = (p + 1) % NP;
                        mInPtr[p]  = (v + 1) % NV;
                        if (!bus.req_tail[p*NV+v]) begin
                            mLockP[o] = p;
                            mLockV[o] = v;
                        end
                    end else if (bus.req_tail[p*NV+v]) begin
                        mLockP[o] = -1;
                    end
`ifdef SA_GRANT_CNT_EN
                    if (mCount[o] < 65535) mCount[o]++;
`endif
                end
            end
        end
    end

    // Compare every DUT output against the model in the middle of each cycle
    always @(negedge clk) begin
        logic [NP-1:0]      eInV;
        logic [NP-1:0][1:0] eInVc;
        logic [NP-1:0]      eOutV;
        logic [NP-1:0][2:0] eOutP;
        logic [NP-1:0]      eLock;
        logic [NP-1:0][1:0] aVc;
        logic [NP-1:0][2:0] aPort;
        if (!reset) begin
            checkOutput("resetValids", {17'd0, bus.in_grant_valid, bus.out_grant_valid, bus.out_locked}, 32'd0);
            checkOutput("resetData", {7'd0, bus.in_grant_vc, bus.out_grant_port}, 32'd0);
        end else begin
            computeModel(eInV, eInVc, eOutV, eOutP);
            for (int i = 0; i < NP; i++) begin
                eLock[i] = (mLockP[i] >= 0);
                aVc[i]   = eInV[i]  ? bus.in_grant_vc[i]    : 2'd0;
                aPort[i] = eOutV[i] ? bus.out_grant_port[i] : 3'd0;
            end
            checkOutput("inGrantValid", 32'(bus.in_grant_valid), 32'(eInV));
            checkOutput("inGrantVc", 32'(aVc), 32'(eInVc));
            checkOutput("outGrantValid", 32'(bus.out_grant_valid), 32'(eOutV));
            checkOutput("outGrantPort", 32'(aPort), 32'(eOutP));
            checkOutput("outLocked", 32'(bus.out_locked), 32'(eLock));
`ifdef SA_GRANT_CNT_EN
            for (int o = 0; o < NP; o++) checkOutput("grantCount", 32'(grantCount[o]), 32'(mCount[o]));
`endif
        end
    end

    // Request helpers
    task automatic clearReqs();
        bus.req_valid     = '0;
        bus.req_dst_port  = '0;
        bus.req_tail      = '0;
        bus.req_credit_ok = '0;
    endtask

    task automatic applyStimulus(input int p, input int v, input logic [NP-1:0] dst,
                                 input logic tail, input logic credit, input logic valid);
        bus.req_valid[p*NV+v]     = valid;
        bus.req_dst_port[p*NV+v]  = dst;
        bus.req_tail[p*NV+v]      = tail;
        bus.req_credit_ok[p*NV+v] = credit;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sampleCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        clearReqs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Watchdog so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a short pseudo-random soak
    initial begin
        int seqA [6];
        int portB [4];
        int lockB [4];
        int seqD [5];
        seqA  = '{1, 3, 4, 1, 3, 4};
        portB = '{1, 1, 1, 2};
        lockB = '{0, 1, 1, 0};
        seqD  = '{0, 1, 2, 3, 0};
        reset = 1'b0;
        clearReqs();

        // Three inputs compete for output 2 with single-flit packets
        doReset();
        applyStimulus(1, 0, 5'b00100, 1'b1, 1'b1, 1'b1);
        applyStimulus(3, 0, 5'b00100, 1'b1, 1'b1, 1'b1);
        applyStimulus(4, 0, 5'b00100, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            sampleCycle();
            checkOutput("rrPort2", 32'(bus.out_grant_port[2]), 32'(seqA[k]));
            checkOutput("rrOutValid", 32'(bus.out_grant_valid), 32'b00100);
            nextCycle();
        end

        // Three-flit packet from (1,0) holds output 3 against input 2
        doReset();
        applyStimulus(2, 1, 5'b01000, 1'b1, 1'b1, 1'b1);
        applyStimulus(1, 0, 5'b01000, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) applyStimulus(1, 0, 5'b01000, 1'b1, 1'b1, 1'b1);
            if (k == 3) applyStimulus(1, 0, 5'b01000, 1'b1, 1'b1, 1'b0);
            sampleCycle();
            checkOutput("wormPort3", 32'(bus.out_grant_port[3]), 32'(portB[k]));
            checkOutput("wormValid3", 32'(bus.out_grant_valid[3]), 32'd1);
            checkOutput("wormLocked3", 32'(bus.out_locked[3]), 32'(lockB[k]));
            nextCycle();
        end

        // Lock owner stalls on credit: output idles but stays locked
        doReset();
        applyStimulus(2, 1, 5'b01000, 1'b1, 1'b1, 1'b1);
        applyStimulus(1, 0, 5'b01000, 1'b0, 1'b1, 1'b1);
        sampleCycle();
        checkOutput("stallHead", 32'(bus.out_grant_port[3]), 32'd1);
        nextCycle();
        applyStimulus(1, 0, 5'b01000, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            sampleCycle();
            checkOutput("stallValid3", 32'(bus.out_grant_valid[3]), 32'd0);
            checkOutput("stallLocked3", 32'(bus.out_locked[3]), 32'd1);
            checkOutput("stallIn2", 32'(bus.in_grant_valid[2]), 32'd0);
            nextCycle();
        end
        applyStimulus(1, 0, 5'b01000, 1'b1, 1'b1, 1'b1);
        sampleCycle();
        checkOutput("stallTail", 32'(bus.out_grant_port[3]), 32'd1);
        checkOutput("stallTailValid", 32'(bus.out_grant_valid[3]), 32'd1);
        nextCycle();
        applyStimulus(1, 0, 5'b01000, 1'b1, 1'b1, 1'b0);
        sampleCycle();
        checkOutput("stallResume", 32'(bus.out_grant_port[3]), 32'd2);
        checkOutput("stallUnlocked", 32'(bus.out_locked[3]), 32'd0);
        nextCycle();

        // All four VCs of input 0 to distinct outputs: one grant per cycle
        doReset();
        for (int v = 0; v < NV; v++) applyStimulus(0, v, 5'(1 << (v + 1)), 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            sampleCycle();
            checkOutput("vcSeq", 32'(bus.in_grant_vc[0]), 32'(seqD[k]));
            checkOutput("vcInValid", 32'(bus.in_grant_valid), 32'b00001);
            checkOutput("vcOutValid", 32'(bus.out_grant_valid), 32'(1 << (seqD[k] + 1)));
            nextCycle();
        end

        // Multi-hot and zero-hot requests are ignored
        doReset();
        applyStimulus(2, 1, 5'b00110, 1'b1, 1'b1, 1'b1);
        applyStimulus(4, 2, 5'b00000, 1'b1, 1'b1, 1'b1);
        applyStimulus(3, 0, 5'b00010, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            sampleCycle();
            checkOutput("badInValid", 32'(bus.in_grant_valid), 32'b01000);
            checkOutput("badOutValid", 32'(bus.out_grant_valid), 32'b00010);
            checkOutput("badPort1", 32'(bus.out_grant_port[1]), 32'd3);
            nextCycle();
        end

        // Reset in mid-packet drops the lock on output 2 immediately
        doReset();
        applyStimulus(3, 2, 5'b00100, 1'b0, 1'b1, 1'b1);
        sampleCycle();
        checkOutput("rstHead", 32'(bus.out_grant_port[2]), 32'd3);
        nextCycle();
        sampleCycle();
        checkOutput("rstLockedBefore", 32'(bus.out_locked), 32'b00100);
        reset = 1'b0;
        #1;
        checkOutput("rstAsyncValids", {17'd0, bus.in_grant_valid, bus.out_grant_valid, bus.out_locked}, 32'd0);
        checkOutput("rstAsyncData", {7'd0, bus.in_grant_vc, bus.out_grant_port}, 32'd0);
        clearReqs();
        nextCycle();
        reset = 1'b1;
        applyStimulus(4, 0, 5'b00100, 1'b1, 1'b1, 1'b1);
        sampleCycle();
        checkOutput("rstNewPort2", 32'(bus.out_grant_port[2]), 32'd4);
        checkOutput("rstNewValid", 32'(bus.out_grant_valid), 32'b00100);
        checkOutput("rstNewLocked", 32'(bus.out_locked), 32'd0);
        nextCycle();

        // Pseudo-random soak checked by the model alone
        doReset();
        for (int c = 0; c < 300; c++) begin
            for (int p = 0; p < NP; p++) begin
                for (int v = 0; v < NV; v++) begin
                    logic [NP-1:0] dst;
                    if ($urandom_range(0, 7) == 0) dst = NP'($urandom_range(0, 31));
                    else dst = NP'(1 << $urandom_range(0, NP - 1));
                    applyStimulus(p, v, dst, ($urandom_range(0, 2) == 0),
                                  ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0));
                end
            end
            nextCycle();
        end
        clearReqs();
        nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_rr_allocator.md
Name: sa_rr_allocator

Overview:
- Separable input-first switch allocator for the 5-port virtual-channel router.
- Sits between the VC allocation stage and buffer read. Each cycle it picks at most one VC per input port and at most one input port per output port.
- Uses round-robin fairness and wormhole output locking, which holds an output for a packet from head flit to tail flit.
- Its grants drive buffer-read VC selection and switch-traversal crossbar select.

Parameters:
- NUM_PORTS, 5, router ports; port 0 is local.
- NUM_VCS, 4, VCs per input port.
- PORT_BITS, $clog2(NUM_PORTS), port index width.
- VC_BITS, $clog2(NUM_VCS), VC index width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- req_valid  input  NUM_PORTS*NUM_VCS  per input VC (index p*NUM_VCS+v): a flit is ready.
- req_dst_port  input  [NUM_PORTS*NUM_VCS][NUM_PORTS]  one-hot output port per input VC, from VC allocation.
- req_tail  input  NUM_PORTS*NUM_VCS  the flit is the tail of its packet (a single-flit packet has tail=1).
- req_credit_ok  input  NUM_PORTS*NUM_VCS  the allocated downstream VC has at least 1 credit.
- in_grant_valid  output  NUM_PORTS  input port p won this cycle.
- in_grant_vc  output  [NUM_PORTS][VC_BITS]  winning VC of input port p.
- out_grant_valid  output  NUM_PORTS  output port o is driven this cycle.
- out_grant_port  output  [NUM_PORTS][PORT_BITS]  input port routed to output o (crossbar select).
- out_locked  output  NUM_PORTS  output o is held by an unfinished packet (registered state).

Behaviour:
- Grants are combinational, with latency 0 from requests. Pointers and locks are registered and update on the rising clk edge.
- While reset=0, all outputs are 0. All in_ptr, out_ptr, lock and owner state is cleared to 0 immediately (asynchronously). Reset in mid-packet drops every lock.
- Eligibility of VC (p,v): all of the following must hold.
  - req_valid=1 and req_credit_ok=1.
  - req_dst_port is exactly one-hot. Zero or multi-hot requests are ignored and never granted.
  - Target output o is either unlocked, or locked with owner == (p,v).
- Stage 1, per input p: round-robin among eligible VCs, starting the search at in_ptr[p] and wrapping from NUM_VCS-1 to 0. This gives the candidate vc_c[p] and its target o.
- Stage 2, per output o: round-robin among inputs whose candidate targets o, starting at out_ptr[o] and wrapping from NUM_PORTS-1 to 0.
  - A locked output considers only its owner input.
  - The winner drives out_grant_valid[o]=1 and out_grant_port[o]=p, plus in_grant_valid[p]=1 and in_grant_vc[p]=vc_c[p].
- Grant invariants: at most one grant per input and at most one per output.
  - A U-turn (p == o) is granted like any other request; filtering U-turns is route compute's job.
- Pointer update (iSLIP style) on a clock edge with a grant:
  - in_ptr[p] <= (vc_c[p]+1) mod NUM_VCS, but only if input p was granted. A losing candidate leaves in_ptr unchanged.
  - out_ptr[o] <= (p+1) mod NUM_PORTS.
  - Pointers do not advance while an output is locked and granted to its owner, so the owner does not lose priority mid-packet.
- Lock FSM per output, with states UNLOCKED and LOCKED(owner p,v):
  - UNLOCKED, granted with tail=0 -> LOCKED(p,v).
  - UNLOCKED, granted with tail=1 -> UNLOCKED (single-flit packet).
  - LOCKED, owner granted with tail=1 -> UNLOCKED on the same edge; the output is open to any input the next cycle.
  - LOCKED, owner req_valid=0 or credit_ok=0 -> stays LOCKED and the output is idle (out_grant_valid=0).
- Simultaneous events:
  - Release by the owner and a new head from another VC in the same cycle: the new head waits 1 cycle.
  - Two VCs of the same input holding locks on different outputs are both legal. Stage 1 round-robin picks one per cycle.

Optional Feature:
- Macro SA_GRANT_CNT_EN.
- Defined: adds output grant_count [NUM_PORTS][16].
  - Per-output counter incremented on each out_grant_valid edge, saturating at 16'hFFFF.
  - Reset to 0 by reset.
- Not defined: the port and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset=0 mid-packet with output 2 LOCKED -> all outputs 0 immediately; after release, out_locked=0 and a new head on output 2 from any input is granted.
- Inputs 1,3,4 each request output 2 with tail=1 every cycle from reset -> out_grant_port[2] sequence is 1,3,4,1,3,4.
  - Each out_grant_valid[2]=1, and no other output is granted.
- Input 1 VC0 sends a 3-flit packet to output 3 (tail on flit 3) while input 2 VC1 requests output 3 continuously.
  - Expect out_grant_port[3]=1 for 3 consecutive cycles, out_locked[3]=1 for the 2 cycles after the head grant, then input 2 granted.
- Input 0 VCs 0..3 all target distinct outputs 1..4 with tail=1 -> a single in_grant each cycle, in_grant_vc[0] sequence 0,1,2,3,0.
- req_credit_ok=0 for lock owner (1,0) on output 3 for 4 cycles -> out_grant_valid[3]=0 and out_locked[3]=1 throughout.
  - Input 2 is never granted output 3 during this window; it resumes after the tail.
- Invalid request: req_dst_port=5'b00110 (multi-hot) on (2,1) -> never granted, while other requests proceed normally.
  - With SA_GRANT_CNT_EN defined, grant_count matches the number of granted cycles per output.
